radio_rx: RTL
=============

Name: radio_rx

Overview:
Serial byte receiver for the sensor-node radio link. It is the receiving end of the radio Tx line: it deserializes UART-style frames (start bit, DATA_BITS data bits LSB first, one stop bit) from the Rx pin. Each good byte is presented on a held valid/ack interface to the node controller, with framing-error and overrun reporting. It sits between the radio pin and the packet/command logic.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period; even, >= 4
DATA_BITS, 8, data bits per frame

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  receiver enable; low aborts any frame in progress
Rx  input  1  asynchronous serial line; idle high
rx_ack  input  1  consumer acknowledges rx_data; clears rx_valid and overrun
rx_data  output  DATA_BITS  last good byte; held until overwritten
rx_valid  output  1  high while an unacknowledged byte is in rx_data
busy  output  1  high whenever state != IDLE
frame_err  output  1  one-cycle pulse on bad stop bit
overrun  output  1  sticky; a new byte landed while rx_valid was still high

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, counters 0, shift register 0, rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0, synchronizer flops=1. Reset mid-frame discards the frame.
- Rx passes through a 2-flop synchronizer. "Line" below means the synchronized value.
- Bit counter counts 0..CLKS_PER_BIT-1. Bit index counts 0..DATA_BITS-1.
- IDLE: if enable=1 and line=0, go to START with counter cleared.
- START: at counter = CLKS_PER_BIT/2-1, sample the line.
  - 0: go to DATA, counter cleared, bit index 0.
  - 1: false start; return to IDLE with no flags.
- DATA: at each counter = CLKS_PER_BIT-1, shift the line into the MSB of the shift register (shift right, so the first bit ends at the LSB). After DATA_BITS samples, go to STOP.
- STOP: at counter = CLKS_PER_BIT-1, sample the line.
  - 1: rx_data <= shift register, rx_valid <= 1, go to IDLE.
  - 0: frame_err=1 for exactly one cycle, data discarded, rx_valid unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until line=1, then go to IDLE. This prevents a held-low line from retriggering.
- Latency: rx_valid rises the cycle after the stop sample. That is CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after IDLE first sees line=0 (153 at default parameters), plus 2 synchronizer cycles from the pin.
- Overrun: if a good stop bit occurs while rx_valid=1 and rx_ack=0:
  - rx_data is overwritten with the new byte;
  - overrun <= 1 (sticky).
- Simultaneous good stop and rx_ack=1: rx_valid stays 1, new data is loaded, overrun unchanged (not set).
- rx_ack=1 with rx_valid=1 and no new byte that cycle: rx_valid <= 0 and overrun <= 0 next cycle. rx_ack while rx_valid=0: ignored.
- enable=0 in any non-IDLE state: go to IDLE next cycle, busy=0, partial byte dropped. rx_valid, rx_data and overrun are untouched.
- enable=0 in IDLE: stays IDLE; the ack path still works.
- frame_err and the overrun set are never generated from an aborted frame.

Decomposition:
- Shared package radio_pkg holds:
  - state encoding: IDLE, START, DATA, STOP, WAIT_HIGH (3-bit);
  - RADIO_CLKS_PER_BIT default, RADIO_DATA_BITS default;
  - line idle level constant.
- One sub-module, radio_sync: a 2-flop synchronizer with reset value 1, reusable by the transmitter loopback bench.
- Counter, shift register and FSM stay in radio_rx.

Test Plan:
All scenarios use CLKS_PER_BIT=16, DATA_BITS=8, bits driven by the bench at 160 ns per bit on a 10 ns clk.
1. Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> rx_data=0xA5, rx_valid rises 153 cycles after IDLE sees line=0 (±0), frame_err=0, busy low afterward.
2. Rx low for 4 cycles, then high -> START aborts at its sample; busy pulses about 8 cycles; rx_valid, frame_err and overrun stay 0.
3. Frame 0x3C with stop bit 0, line held low 3 more bit times -> one-cycle frame_err, rx_valid=0, busy held until line high. Then frame 0x5A -> rx_data=0x5A, rx_valid=1.
4. Frames 0x11 then 0x22 with no ack -> after the second frame, rx_data=0x22, rx_valid=1, overrun=1. Pulse rx_ack -> rx_valid=0 and overrun=0 next cycle.
5. Frame 0x77 with rx_ack asserted exactly on the stop-sample cycle while 0x66 is pending -> rx_valid=1, rx_data=0x77, overrun=0.
6. Mid-frame (during bit 3), drop enable for 1 cycle -> busy=0 next cycle, no rx_valid. Re-enable with frame 0xFF -> rx_data=0xFF. Separately, rst mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/radio_pkg.sv
// Shared definitions for the radio serial link: FSM states and link defaults.
package radio_pkg;

  localparam int unsigned RADIO_CLKS_PER_BIT = 16;
  localparam int unsigned RADIO_DATA_BITS    = 8;

  // Level of the serial line between frames.
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

endpackage

// File: rtl/radio_sync.sv
// Two-flop synchronizer for an asynchronous serial line; resets to the idle level.
module radio_sync
  import radio_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; reset to idle so no false start is seen after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= LINE_IDLE;
      q    <= LINE_IDLE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/radio_rx.sv
// UART-style serial byte receiver with held valid/ack output, framing error and overrun.
module radio_rx
  import radio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = RADIO_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = RADIO_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 Rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic line;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n, busy_n, ferr_n, ovr_n;

  radio_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (Rx),
    .q   (line)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      busy      <= busy_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  // Next-state and output logic; ack handling first, a good stop bit overrides it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = rx_data;
    valid_n = rx_valid;
    ferr_n  = 1'b0;
    ovr_n   = overrun;

    if (rx_ack && rx_valid) begin
      valid_n = 1'b0;
      ovr_n   = 1'b0;
    end

    if (!enable && (state != IDLE)) begin
      // Abort: drop the partial byte, leave the delivered byte and flags alone.
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable && !line) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = line ? IDLE : DATA;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            shreg_n = {line, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) begin
              idx_n   = '0;
              state_n = STOP;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            if (line) begin
              data_n  = shreg;
              valid_n = 1'b1;
              ovr_n   = overrun | (rx_valid & ~rx_ack);
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = WAIT_HIGH;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (line == LINE_IDLE) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
    end

    busy_n = (state_n != IDLE);
  end

endmodule
